// File: rtl/sdrc_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdrc_req_arb
// Purpose  : Four-port round-robin request arbiter in front of the SDRAM
//            request generator. One request is in flight at a time. The
//            winning port's fields are latched and presented on m_*, and the
//            port index is prepended to the request ID.
// Options  : SDRC_ARB_PRIO0_EN - when defined, port 0 has strict priority.
//            Port 0 grants do not advance the round-robin pointer, so ports
//            1-3 keep rotating among themselves.
// Ports    : clk, reset_n (synchronous, active low)
//            p_*        : packed per-port request channel, port i in slice i
//            p_ack      : one-hot accept pulse to the owning port
//            m_*        : latched request toward the generator, m_req_ack back
//            grant      : one-hot current owner, arb_busy while granting
// Revision : 1.0 - initial release
// ============================================================================
module sdrc_req_arb #(
    parameter int APP_AW = 30,
    parameter int APP_RW = 9,
    parameter int PID_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               p_req,
    input  logic [4*PID_W-1:0]       p_id,
    input  logic [4*(APP_AW+1)-1:0]  p_addr,
    input  logic [4*(APP_AW-1)-1:0]  p_addr_mask,
    input  logic [4*APP_RW-1:0]      p_len,
    input  logic [3:0]               p_wr_n,
    input  logic [3:0]               p_wrap,
    output logic [3:0]               p_ack,
    output logic                     m_req,
    output logic [PID_W+1:0]         m_id,
    output logic [APP_AW:0]          m_addr,
    output logic [APP_AW-2:0]        m_addr_mask,
    output logic [APP_RW-1:0]        m_len,
    output logic                     m_wr_n,
    output logic                     m_wrap,
    input  logic                     m_req_ack,
    output logic [3:0]               grant,
    output logic                     arb_busy
);

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    arb_state_t              state_q;
    logic [1:0]              last_ptr_q;
    logic [1:0]              owner_q;
    logic [3:0]              grant_q;
    logic                    m_req_q;
    logic [PID_W+1:0]        m_id_q;
    logic [APP_AW:0]         m_addr_q;
    logic [APP_AW-2:0]       m_addr_mask_q;
    logic [APP_RW-1:0]       m_len_q;
    logic                    m_wr_n_q;
    logic                    m_wrap_q;

    logic [1:0]              w_win;
    logic                    w_found;

    // Scan starting one past the last winner; first requesting port wins.
    always_comb begin
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && p_req[2'(last_ptr_q + 2'(k))]) begin
                w_win   = 2'(last_ptr_q + 2'(k));
                w_found = 1'b1;
            end
        end
`ifdef SDRC_ARB_PRIO0_EN
        if (p_req[0]) begin
            w_win = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            last_ptr_q    <= 2'd3;
            owner_q       <= 2'd0;
            grant_q       <= 4'b0000;
            m_req_q       <= 1'b0;
            m_id_q        <= '0;
            m_addr_q      <= '0;
            m_addr_mask_q <= '0;
            m_len_q       <= '0;
            m_wr_n_q      <= 1'b0;
            m_wrap_q      <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|p_req) begin
                        m_id_q        <= {w_win, p_id[w_win*PID_W +: PID_W]};
                        m_addr_q      <= p_addr[w_win*(APP_AW+1) +: (APP_AW+1)];
                        m_addr_mask_q <= p_addr_mask[w_win*(APP_AW-1) +: (APP_AW-1)];
                        m_len_q       <= p_len[w_win*APP_RW +: APP_RW];
                        m_wr_n_q      <= p_wr_n[w_win];
                        m_wrap_q      <= p_wrap[w_win];
                        grant_q       <= 4'b0001 << w_win;
                        owner_q       <= w_win;
                        m_req_q       <= 1'b1;
                        state_q       <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // Fields stay frozen until the generator accepts.
                    if (m_req_ack) begin
                        m_req_q <= 1'b0;
                        grant_q <= 4'b0000;
`ifdef SDRC_ARB_PRIO0_EN
                        if (owner_q != 2'd0) begin
                            last_ptr_q <= owner_q;
                        end
`else
                        last_ptr_q <= owner_q;
`endif
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // grant_q is zero outside ARB_GRANT, so an ack seen while idle is ignored.
    // Reset masks both outputs immediately, so an aborted grant never acks.
    assign p_ack       = reset_n ? (grant_q & {4{m_req_ack}}) : 4'b0000;
    assign arb_busy    = reset_n && (state_q == ARB_GRANT);

    assign grant       = grant_q;
    assign m_req       = m_req_q;
    assign m_id        = m_id_q;
    assign m_addr      = m_addr_q;
    assign m_addr_mask = m_addr_mask_q;
    assign m_len       = m_len_q;
    assign m_wr_n      = m_wr_n_q;
    assign m_wrap      = m_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_sdrc_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdrc_req_arb
// Purpose  : Self-checking bench for sdrc_req_arb. Directed scenarios followed
//            by random traffic, all compared each cycle against a
//            transaction-level model of the arbiter (owner, pointer and
//            latched fields tracked as plain integers and vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdrc_req_arb;

    localparam int APP_AW = 30;
    localparam int APP_RW = 9;
    localparam int PID_W  = 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [3:0]               p_req;
    logic [4*PID_W-1:0]       p_id;
    logic [4*(APP_AW+1)-1:0]  p_addr;
    logic [4*(APP_AW-1)-1:0]  p_addr_mask;
    logic [4*APP_RW-1:0]      p_len;
    logic [3:0]               p_wr_n;
    logic [3:0]               p_wrap;
    logic [3:0]               p_ack;
    logic                     m_req;
    logic [PID_W+1:0]         m_id;
    logic [APP_AW:0]          m_addr;
    logic [APP_AW-2:0]        m_addr_mask;
    logic [APP_RW-1:0]        m_len;
    logic                     m_wr_n;
    logic                     m_wrap;
    logic                     m_req_ack;
    logic [3:0]               grant;
    logic                     arb_busy;

    sdrc_req_arb #(.APP_AW(APP_AW), .APP_RW(APP_RW), .PID_W(PID_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_req(p_req), .p_id(p_id), .p_addr(p_addr), .p_addr_mask(p_addr_mask),
        .p_len(p_len), .p_wr_n(p_wr_n), .p_wrap(p_wrap), .p_ack(p_ack),
        .m_req(m_req), .m_id(m_id), .m_addr(m_addr), .m_addr_mask(m_addr_mask),
        .m_len(m_len), .m_wr_n(m_wr_n), .m_wrap(m_wrap), .m_req_ack(m_req_ack),
        .grant(grant), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner = -1 when nobody holds the channel.
    int                 mdl_owner = -1;
    int                 mdl_last  = 3;
    logic [PID_W+1:0]   mdl_id;
    logic [APP_AW:0]    mdl_addr;
    logic [APP_AW-2:0]  mdl_mask;
    logic [APP_RW-1:0]  mdl_len;
    logic               mdl_wr_n;
    logic               mdl_wrap;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies the arbitration rules to the inputs present at this clock edge.
    task automatic model_update();
        int w;
        if (!reset_n) begin
            mdl_owner = -1;
            mdl_last  = 3;
            mdl_id    = '0;
            mdl_addr  = '0;
            mdl_mask  = '0;
            mdl_len   = '0;
            mdl_wr_n  = 1'b0;
            mdl_wrap  = 1'b0;
        end else if (mdl_owner < 0) begin
            if (p_req != 4'b0000) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && p_req[(mdl_last + k) % 4]) w = (mdl_last + k) % 4;
                end
`ifdef SDRC_ARB_PRIO0_EN
                if (p_req[0]) w = 0;
`endif
                mdl_owner = w;
                mdl_id    = {2'(w), p_id[w*PID_W +: PID_W]};
                mdl_addr  = p_addr[w*(APP_AW+1) +: (APP_AW+1)];
                mdl_mask  = p_addr_mask[w*(APP_AW-1) +: (APP_AW-1)];
                mdl_len   = p_len[w*APP_RW +: APP_RW];
                mdl_wr_n  = p_wr_n[w];
                mdl_wrap  = p_wrap[w];
            end
        end else if (m_req_ack) begin
`ifdef SDRC_ARB_PRIO0_EN
            if (mdl_owner != 0) mdl_last = mdl_owner;
`else
            mdl_last = mdl_owner;
`endif
            mdl_owner = -1;
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = (mdl_owner >= 0) ? 4'(1 << mdl_owner) : 4'b0000;
        check_val("m_req",    64'(m_req),    64'(mdl_owner >= 0));
        check_val("grant",    64'(grant),    64'(eg));
        check_val("p_ack",    64'(p_ack),    64'((reset_n && m_req_ack) ? eg : 4'b0000));
        check_val("arb_busy", 64'(arb_busy), 64'(reset_n && mdl_owner >= 0));
        check_val("m_id",     64'(m_id),     64'(mdl_id));
        check_val("m_addr",   64'(m_addr),   64'(mdl_addr));
        check_val("m_mask",   64'(m_addr_mask), 64'(mdl_mask));
        check_val("m_len",    64'(m_len),    64'(mdl_len));
        check_val("m_wr_n",   64'(m_wr_n),   64'(mdl_wr_n));
        check_val("m_wrap",   64'(m_wrap),   64'(mdl_wrap));
    endtask

    // One clock: model absorbs the edge, new inputs are driven just after
    // it, and outputs are compared on the falling edge.
    task automatic do_cycle(input logic [3:0] req, input logic ack, input logic rstn);
        @(posedge clk);
        model_update();
        #1;
        p_req     = req;
        m_req_ack = ack;
        reset_n   = rstn;
        @(negedge clk);
        compare_all();
    endtask

    task automatic randomize_fields();
        p_id        = 8'($urandom);
        p_addr      = {$urandom, $urandom, $urandom, $urandom};
        p_addr_mask = {$urandom, $urandom, $urandom, $urandom};
        p_len       = {$urandom, $urandom};
        p_wr_n      = 4'($urandom);
        p_wrap      = 4'($urandom);
    endtask

    initial begin
        reset_n = 1'b0; m_req_ack = 1'b0; p_req = 4'b0000;
        p_id = '0; p_addr = '0; p_addr_mask = '0; p_len = '0; p_wr_n = '0; p_wrap = '0;
        mdl_id = '0; mdl_addr = '0; mdl_mask = '0; mdl_len = '0; mdl_wr_n = 0; mdl_wrap = 0;

        // Reset state
        do_cycle(4'b0000, 1'b0, 1'b0);
        do_cycle(4'b0000, 1'b0, 1'b0);
        check_val("rst_m_req", 64'(m_req), 64'd0);

        // Single request on port 2, held for 5 cycles before accept
        randomize_fields();
        p_addr[2*(APP_AW+1) +: (APP_AW+1)] = 31'h0001_2340;
        p_len[2*APP_RW +: APP_RW]          = 9'd8;
        p_id[2*PID_W +: PID_W]             = 2'd1;
        do_cycle(4'b0100, 1'b0, 1'b1);
        check_val("t1_m_req_early", 64'(m_req), 64'd0);
        do_cycle(4'b0100, 1'b0, 1'b1);
        check_val("t1_m_req", 64'(m_req),  64'd1);
        check_val("t1_addr",  64'(m_addr), 64'h0001_2340);
        check_val("t1_len",   64'(m_len),  64'd8);
        check_val("t1_id",    64'(m_id),   64'b1001);
        check_val("t1_grant", 64'(grant),  64'b0100);
        repeat (4) do_cycle(4'b0100, 1'b0, 1'b1);
        check_val("t1_addr_hold", 64'(m_addr), 64'h0001_2340);
        do_cycle(4'b0100, 1'b1, 1'b1);
        check_val("t1_p_ack", 64'(p_ack), 64'b0100);
        do_cycle(4'b0000, 1'b0, 1'b1);
        check_val("t1_m_req_drop", 64'(m_req), 64'd0);

        // All ports requesting with immediate accept, starting from reset
        do_cycle(4'b0000, 1'b0, 1'b0);
        repeat (10) begin
            randomize_fields();
            do_cycle(4'b1111, 1'b1, 1'b1);
        end

        // Reset in the middle of a port-1 grant, then 0011 -> port 0
        do_cycle(4'b0000, 1'b0, 1'b1);
        do_cycle(4'b0010, 1'b0, 1'b1);
        do_cycle(4'b0010, 1'b0, 1'b1);
        check_val("t3_grant", 64'(grant), 64'b0010);
        do_cycle(4'b0010, 1'b1, 1'b0);
        check_val("t3_no_ack", 64'(p_ack), 64'd0);
        do_cycle(4'b0011, 1'b0, 1'b1);
        check_val("t3_rst_m_req", 64'(m_req), 64'd0);
        check_val("t3_rst_grant", 64'(grant), 64'd0);
        do_cycle(4'b0011, 1'b0, 1'b1);
        check_val("t3_port0", 64'(grant), 64'b0001);
        do_cycle(4'b0000, 1'b1, 1'b1);

        // Ack while idle is ignored
        do_cycle(4'b0000, 1'b1, 1'b1);
        check_val("t4_idle_ack", 64'(p_ack), 64'd0);
        check_val("t4_busy",     64'(arb_busy), 64'd0);

        // Port 3 drops its request after being granted
        do_cycle(4'b1000, 1'b0, 1'b1);
        do_cycle(4'b1000, 1'b0, 1'b1);
        do_cycle(4'b0000, 1'b0, 1'b1);
        do_cycle(4'b0000, 1'b0, 1'b1);
        check_val("t5_m_req_held", 64'(m_req), 64'd1);
        do_cycle(4'b0000, 1'b1, 1'b1);
        check_val("t5_p_ack", 64'(p_ack), 64'b1000);

        // Random traffic with occasional resets
        repeat (3000) begin
            randomize_fields();
            do_cycle(4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
